// File: rtl/zifi_uart_core_pkg.sv
// zifi_uart_core_pkg: shared FSM state encodings and the baud divisor helper for the ZiFi UART.
package zifi_uart_core_pkg;
  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_STOP  = 3'd3;
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/zifi_uart_fifo.sv
// zifi_uart_fifo: single-clock FIFO with a registered head output (zero when empty).
module zifi_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk_bus,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok, pop_ok;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = head_q;
  assign count_o = count_q;
  // The head entry may be the byte being written this very cycle, so bypass it from din.
  always_comb begin
    rp_d    = rp_q + AW'(pop_ok);
    wp_d    = wp_q + AW'(push_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_d  = (count_d == '0) ? '0 : (count_q == (AW+1)'(pop_ok)) ? din_i : mem_q[rp_d];
  end
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end
  always_ff @(posedge clk_bus) begin
    if (push_ok) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/zifi_uart_core.sv
// zifi_uart_core: 8N1 UART engine with RX FIFO and rts flow control for the ZX-Uno ZiFi port.
// Define UART_FRAME_CHECK_EN to discard received bytes whose stop bit is 0 and flag rx_ferr.
module zifi_uart_core
  import zifi_uart_core_pkg::*;
#(
  parameter int CLK_HZ     = 28000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic       clk_bus,
  input  logic       rst,
  input  logic [7:0] txdata,
  input  logic       txbegin,
  output logic       txbusy,
  output logic [7:0] rxdata,
  output logic       rxrecv,
  input  logic       data_read,
  input  logic       rx,
  output logic       tx,
  output logic       rts,
  output logic       rx_ferr
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
`ifdef UART_FRAME_CHECK_EN
  localparam logic FRAME_CHECK = 1'b1;
`else
  localparam logic FRAME_CHECK = 1'b0;
`endif
  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_tick;
  assign tx_tick = tx_cnt_q == LAST;
  assign txbusy  = tx_state_q != TX_IDLE;
  assign tx      = (tx_state_q == TX_START) ? 1'b0 : (tx_state_q == TX_DATA) ? tx_sh_q[0] : 1'b1;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == TX_IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    if (tx_state_q == TX_IDLE && txbegin) begin
      tx_state_d = TX_START;
      tx_sh_d    = txdata;
    end else if (tx_tick) begin
      if (tx_state_q == TX_START) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end else if (tx_state_q == TX_DATA) begin
        tx_sh_d    = tx_sh_q >> 1;
        tx_bit_d   = tx_bit_q + 1'b1;
        tx_state_d = (tx_bit_q == 3'd7) ? TX_STOP : TX_DATA;
      end else if (tx_state_q == TX_STOP) begin
        tx_state_d = TX_IDLE;
      end
    end
  end
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          stop_tick, push, frame_err, rd_q, rd_rise;
  logic          rx_ferr_q, rx_ferr_d, rts_q, rts_d;
  logic          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  // rx_s3_q is only an edge-detect delay; rx_s2_q is the synchronised line.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    stop_tick  = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      rx_cnt_d   = '0;
      rx_state_d = (rx_s3_q && !rx_s2_q) ? RX_START : RX_IDLE;
    end else if (rx_state_q == RX_START) begin
      if (rx_cnt_q == HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
    end else if (rx_state_q == RX_DATA) begin
      if (rx_cnt_q == LAST) begin
        rx_cnt_d   = '0;
        rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
    end else if (rx_cnt_q == LAST) begin
      rx_cnt_d   = '0;
      rx_state_d = RX_IDLE;
      stop_tick  = 1'b1;
    end
  end
  assign rd_rise   = data_read & ~rd_q;
  assign push      = stop_tick & (rx_s2_q | ~FRAME_CHECK);
  assign frame_err = stop_tick & ~rx_s2_q & FRAME_CHECK;
  assign rx_ferr_d = (push & fifo_full) | frame_err | (rx_ferr_q & ~rd_rise);
  assign rts_d     = (FIFO_DEPTH - int'(fifo_count)) <= RTS_MARGIN;
  assign rx_ferr   = rx_ferr_q;
  assign rts       = rts_q;
  assign rxrecv    = ~fifo_empty;
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rd_q       <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rd_q       <= data_read;
      rx_ferr_q  <= rx_ferr_d;
      rts_q      <= rts_d;
    end
  end
  zifi_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk_bus (clk_bus),
    .rst     (rst),
    .push_i  (push),
    .din_i   (rx_sh_q),
    .pop_i   (rd_rise),
    .head_o  (rxdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
endmodule

// File: tb/tb_zifi_uart_core.sv
// tb_zifi_uart_core: directed self-checking bench for zifi_uart_core at 28 MHz / 115200 baud.
module tb_zifi_uart_core;
  localparam int DIV = 243;
  logic       clk_bus = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txdata = '0;
  logic       txbegin = 1'b0;
  logic       txbusy;
  logic [7:0] rxdata;
  logic       rxrecv;
  logic       data_read = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic       rts;
  logic       rx_ferr;
  int checks = 0;
  int passed = 0;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_recv;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];
  always #5 clk_bus = ~clk_bus;
  zifi_uart_core dut (
    .clk_bus   (clk_bus),
    .rst       (rst),
    .txdata    (txdata),
    .txbegin   (txbegin),
    .txbusy    (txbusy),
    .rxdata    (rxdata),
    .rxrecv    (rxrecv),
    .data_read (data_read),
    .rx        (rx),
    .tx        (tx),
    .rts       (rts),
    .rx_ferr   (rx_ferr)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_bus);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(DIV);
    end
    rx = 1'b1;
    tick(20);
  endtask
  task automatic read_pulse(input int hold);
    data_read = 1'b1;
    tick(hold);
    data_read = 1'b0;
    tick(2);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [9:0] ef;
    int busy;
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
`ifdef UART_FRAME_CHECK_EN
    vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1};
`else
    vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0};
`endif
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_tx", tx, 1);
    check("rst_txbusy", txbusy, 0);
    check("rst_rxrecv", rxrecv, 0);
    check("rst_rxdata", rxdata, 0);
    check("rst_rts", rts, 0);
    check("rst_ferr", rx_ferr, 0);
    // transmit A5h: sample every bit at its centre and count busy cycles
    txdata = 8'hA5;
    txbegin = 1'b1;
    tick(1);
    txbegin = 1'b0;
    ef = {1'b1, 8'hA5, 1'b0};
    busy = 0;
    for (int k = 0; k < 2440; k++) begin
      if (txbusy) busy++;
      if (k % DIV == 121 && k < 10 * DIV) check($sformatf("tx_bit%0d", k / DIV), tx, ef[k / DIV]);
      tick(1);
    end
    check("tx_busy_len", busy, 2430);
    check("tx_idle_after", tx, 1);
    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].d, vecs[v].stop);
      check($sformatf("vec%0d_recv", v), rxrecv, vecs[v].exp_recv);
      check($sformatf("vec%0d_data", v), rxdata, vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), rx_ferr, vecs[v].exp_ferr);
      read_pulse(3);
      check($sformatf("vec%0d_empty", v), rxrecv, 0);
      check($sformatf("vec%0d_ferr_clr", v), rx_ferr, 0);
    end
    // long data_read strobe must pop exactly one entry
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    read_pulse(8);
    check("hold_recv", rxrecv, 1);
    check("hold_data", rxdata, 8'h7E);
    read_pulse(8);
    check("hold_empty", rxrecv, 0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 10) check("rts_at11", rts, 0);
      if (i == 11) check("rts_at12", rts, 1);
    end
    send_byte(8'hAA, 1'b1);
    check("full_ferr", rx_ferr, 1);
    check("full_head", rxdata, 8'h00);
    check("full_rts", rts, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), rxdata, 32'(i));
      read_pulse(2);
    end
    check("drain_empty", rxrecv, 0);
    check("drain_rts", rts, 0);
    check("drain_ferr", rx_ferr, 0);
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(400);
    check("glitch_recv", rxrecv, 0);
    check("glitch_ferr", rx_ferr, 0);
    // reset during TX data bit 4 with three bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("pre_rst_head", rxdata, 8'h11);
    txdata = 8'h00;
    txbegin = 1'b1;
    tick(1);
    txbegin = 1'b0;
    tick(5 * DIV + 100);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", txbusy, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", txbusy, 0);
    check("mid_rst_recv", rxrecv, 0);
    check("mid_rst_rts", rts, 0);
    check("mid_rst_data", rxdata, 0);
    rst = 1'b0;
    tick(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
